// File: rtl/mmio_uart_tx_arbiter_pkg.sv
// Shared IO constants for the UART TX path: FSM encodings and UART MMIO map.
package mmio_uart_tx_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [31:0] UART_RX_ADDR     = 32'h8000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;

endpackage

// File: rtl/mmio_uart_tx_arbiter_rr.sv
// Two-way round-robin winner selection with a last-grant pointer.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);

  // 0 = req0 granted last, 1 = req1 granted last
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mmio_uart_tx_arbiter.sv
// Arbitrates two byte sources (CPU MMIO store, debug/echo) onto one UART
// transmitter, with per-source delivered-byte counters.
module mmio_uart_tx_arbiter
  import mmio_uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [7:0]           req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] req0_count,
  output logic [CNT_WIDTH-1:0] req1_count,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t     state, state_nxt;
  logic [7:0] hold_q;
  logic       gnt_q;
  logic [1:0] grant;
  logic       accept;
  logic       deliver;

  rr_arbiter_2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .upd    (deliver),
    .upd_id (gnt_q),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    accept     = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        // readies are combinational from valid, so gate them while in reset
        req0_ready = grant[0] && !rst;
        req1_ready = grant[1] && !rst;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = hold_q;
        deliver  = tx_ready;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      gnt_q  <= 1'b0;
    end else if (accept) begin
      hold_q <= grant[1] ? req1_data : req0_data;
      gnt_q  <= grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_count <= '0;
      req1_count <= '0;
    end else begin
      if (cnt_clear)                req0_count <= '0;
      else if (deliver && !gnt_q)   req0_count <= req0_count + CNT_ONE;
      if (cnt_clear)                req1_count <= '0;
      else if (deliver && gnt_q)    req1_count <= req1_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx_arbiter.sv
// Directed bench for mmio_uart_tx_arbiter; a 4-bit-counter twin shares all
// inputs so counter wrap can be observed against the 32-bit instance.
module tb_mmio_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req0_data, req1_data;
  logic        req0_valid, req1_valid, tx_ready, cnt_clear;
  logic        req0_ready, req1_ready, tx_valid, busy;
  logic [7:0]  tx_data;
  logic [31:0] req0_count, req1_count;

  logic        w_req0_ready, w_req1_ready, w_tx_valid, w_busy;
  logic [7:0]  w_tx_data;
  logic [3:0]  w_req0_count, w_req1_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_uart_tx_arbiter #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cnt_clear(cnt_clear), .req0_count(req0_count), .req1_count(req1_count),
    .busy(busy)
  );

  mmio_uart_tx_arbiter #(.CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(w_req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(w_req1_ready),
    .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(tx_ready),
    .cnt_clear(cnt_clear), .req0_count(w_req0_count), .req1_count(w_req1_count),
    .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
  endtask

  logic [7:0] seq_data [4] = '{8'hAA, 8'h55, 8'hAA, 8'h55};

  initial begin
    rst = 1'b1;
    req0_data = '0; req1_data = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tx_ready = 1'b0; cnt_clear = 1'b0;

    // reset state, with a requester already valid
    req0_valid = 1'b1;
    #12;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req0_count", req0_count, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single req0 byte 0x41
    req0_valid = 1'b1; req0_data = 8'h41; tx_ready = 1'b1;
    #1;
    check("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("t1_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("t1_idle_tx_valid", {31'b0, tx_valid}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_tx_valid", {31'b0, tx_valid}, 32'd1);
    check("t1_tx_data", {24'b0, tx_data}, 32'h41);
    check("t1_send_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("t1_count", req0_count, 32'd1);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);

    // contention round-robin
    pulse_reset();
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 1) begin
        check("t2_tx_valid", {31'b0, tx_valid}, 32'd1);
        check("t2_tx_data", {24'b0, tx_data}, {24'b0, seq_data[i/2]});
      end else begin
        check("t2_grant", {30'b0, req1_ready, req0_ready},
              (seq_data[i/2] == 8'hAA) ? 32'd1 : 32'd2);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_req0_count", req0_count, 32'd2);
    check("t2_req1_count", req1_count, 32'd2);

    // backpressure: req1 0x7E held for 5 cycles
    req1_valid = 1'b1; req1_data = 8'h7E; tx_ready = 1'b0;
    #1;
    check("t3_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0; req1_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_valid", {31'b0, tx_valid}, 32'd1);
      check("t3_hold_data", {24'b0, tx_data}, 32'h7E);
      check("t3_hold_count", req1_count, 32'd2);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check("t3_count", req1_count, 32'd3);
    check("t3_busy", {31'b0, busy}, 32'd0);

    // reset mid-SEND; first leave the pointer at req0
    req0_valid = 1'b1; req0_data = 8'h10;
    tick();
    req0_valid = 1'b0;
    tick();
    check("t4_pre_count", req0_count, 32'd3);
    req1_valid = 1'b1; req1_data = 8'h33; tx_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    check("t4_send_data", {24'b0, tx_data}, 32'h33);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("t4_rst_busy", {31'b0, busy}, 32'd0);
    check("t4_rst_counts", req0_count | req1_count, 32'd0);
    #1 rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h21;
    req1_valid = 1'b1; req1_data = 8'h22;
    tx_ready = 1'b1;
    #1;
    check("t4_grant", {30'b0, req1_ready, req0_ready}, 32'd1);

    // cnt_clear on a req0 delivery cycle
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0; cnt_clear = 1'b1;
    #1;
    check("t5_tx_data", {24'b0, tx_data}, 32'h21);
    tick();
    cnt_clear = 1'b0;
    check("t5_count", req0_count, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);

    // 16 deliveries: 4-bit counter wraps, 32-bit counter reaches 16
    req0_valid = 1'b1; req0_data = 8'h5A;
    for (int i = 0; i < 32; i++) tick();
    req0_valid = 1'b0;
    check("t6_wrap", {28'b0, w_req0_count}, 32'd0);
    check("t6_count32", req0_count, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
